pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Sequences the program counter and instruction-memory fetch for the RV32I core. Holds the PC register and issues one fetch request at a time over a req/ack handshake. Selects between sequential (PC+4) and branch (PC+ImmOp) next-PC. Captures branch redirects that arrive mid-fetch and honours pipeline stall.

Parameters:
WIDTH, 32, PC/address/immediate width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
en  input  1  run enable; 0 parks the fetcher in IDLE
stall  input  1  core hold request; blocks PC advance
PCsrc  input  1  branch-taken strobe for the instruction at current PC
ImmOp  input  WIDTH  branch offset, two's complement; valid when PCsrc=1
imem_ack  input  1  instruction memory completes the outstanding request
imem_req  output  1  fetch request, held until ack
imem_addr  output  WIDTH  fetch address (= PC)
instr_valid  output  1  1-cycle pulse, cycle after ack
PC  output  WIDTH  current program counter
redirect_pending  output  1  captured branch target awaiting application
trap  output  1  misaligned-target flag (see Optional Feature; tied 0 otherwise)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, PC=RESET_PC, imem_req=0, instr_valid=0, redirect_pending=0, target reg=0, trap=0. Reset mid-transaction drops imem_req immediately; an outstanding ack is ignored after release.
- States: IDLE, REQ, HOLD.
- IDLE: imem_req=0. en=1 -> REQ next cycle.
- REQ: imem_req=1, imem_addr=PC. Stay in REQ until imem_ack=1. On the ack cycle:
  - instr_valid=1 on the following cycle. Fetch latency is 1 cycle from ack.
  - en=0 -> IDLE, PC still advances as below.
  - stall=1 -> HOLD, PC unchanged.
  - Otherwise PC <= next_pc, and the state stays REQ. Back-to-back fetches yield one instruction per ack.
- HOLD: imem_req=0. When stall=0, PC <= next_pc and the state moves to REQ, or to IDLE if en=0.
- en deasserted in REQ before ack: the request stays asserted until ack. No request is abandoned.
- next_pc selection, highest priority first:
  - PCsrc=1 in the update cycle -> PC+ImmOp.
  - redirect_pending=1 -> the latched target.
  - Otherwise PC+4.
- Redirect capture: PCsrc=1 in any cycle that does not update PC latches target=PC+ImmOp and sets redirect_pending. A later PCsrc overwrites the target (newest wins). redirect_pending clears on the PC update that consumes it.
- Arithmetic: all sums are modulo 2^WIDTH. 0xFFFFFFFC+4 = 0x00000000. Negative ImmOp wraps normally. There is no carry out.
- PCsrc/ImmOp are sampled only when state != IDLE. In IDLE they are ignored.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: the selected next_pc is checked. If next_pc[1:0] != 0, PC is still loaded, trap is set (sticky until reset), and the state is forced to IDLE. No further requests are issued regardless of en.
- Undefined: there is no alignment check. The trap port is tied to 0 and misaligned addresses are fetched as-is.

Test Plan:
1. Reset release with RESET_PC=0, en=1, ack returned every request cycle -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; instr_valid pulses once per ack, one cycle later.
2. PC=0x10 with PCsrc=1, ImmOp=0xFFFFFFF8 on the ack cycle -> next imem_addr=0x08. Then ImmOp=0x20 at PC=0x08 -> 0x28.
3. Redirect capture: PCsrc=1, ImmOp=0x100 at PC=0x40 two cycles before ack -> redirect_pending=1 until ack; next address 0x140; redirect_pending=0 afterwards.
4. Stall: stall=1 on the ack cycle at PC=0x20, held 3 cycles -> imem_req=0 and PC=0x20 for 3 cycles; after release, imem_addr=0x24.
5. Wrap and reset: RESET_PC=0xFFFFFFFC -> second address 0x0. Then rst_n pulled low while imem_req=1 -> imem_req=0, PC=RESET_PC in the same cycle, no instr_valid.
6. With MISALIGN_TRAP_EN defined: PC=0x0, PCsrc=1, ImmOp=0x6 -> PC=0x6, trap=1, state IDLE, imem_req remains 0 with en=1.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - RV32I program counter and instruction fetch sequencer
// Optional feature: define MISALIGN_TRAP_EN to trap on a misaligned next PC.
module pc_fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             stall,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] PC,
  output logic             redirect_pending,
  output logic             trap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] branch_pc;
  logic [WIDTH-1:0] next_pc;
  logic             pending_q;
  logic             valid_q;
  logic             pc_update;

  // The PC moves only on an unstalled ack or on leaving HOLD.
  assign pc_update = ((state_q == S_REQ) && imem_ack && !stall) ||
                     ((state_q == S_HOLD) && !stall);

  // Branch target and next-PC selection: live branch beats a captured one.
  always_comb begin
    branch_pc = pc_q + ImmOp;
    next_pc   = pc_q + WIDTH'(4);
    if (PCsrc) begin
      next_pc = branch_pc;
    end else if (pending_q) begin
      next_pc = target_q;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_q;
  logic misaligned;

  assign misaligned = pc_update && (next_pc[1:0] != 2'b00);
  assign trap       = trap_q;

  // Sticky trap flag, set by loading a misaligned PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else if (misaligned) begin
      trap_q <= 1'b1;
    end
  end
`else
  assign trap = 1'b0;
`endif

  // Next-state logic for the fetch handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (en) state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          if (stall) begin
            state_d = S_HOLD;
          end else if (!en) begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: if (!stall) state_d = en ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef MISALIGN_TRAP_EN
    // A trapped fetcher parks for good until reset.
    if (misaligned || trap_q) begin
      state_d = S_IDLE;
    end
`endif
  end

  // State, PC, redirect capture and fetch-done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      target_q  <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == S_REQ) && imem_ack;
      if (pc_update) begin
        pc_q      <= next_pc;
        pending_q <= 1'b0;
      end else if ((state_q != S_IDLE) && PCsrc) begin
        // Newest branch wins; it is applied at the next PC update.
        target_q  <= branch_pc;
        pending_q <= 1'b1;
      end
    end
  end

  assign imem_req         = (state_q == S_REQ);
  assign imem_addr        = pc_q;
  assign PC               = pc_q;
  assign instr_valid      = valid_q;
  assign redirect_pending = pending_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] ImmOp = '0;
  logic        imem_ack = 1'b0;

  logic        imem_req, instr_valid, redirect_pending, trap;
  logic [31:0] imem_addr, PC;
  logic        w_req, w_valid, w_pend, w_trap;
  logic [31:0] w_addr, w_pc;

  int checks = 0;
  int failures = 0;

  // Reference model: phase flags, PC, captured branch, expected pulse.
  bit          m_req, m_hold, m_pend, m_valid, m_trap;
  logic [31:0] m_pc, m_tgt;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .PCsrc(PCsrc),
    .ImmOp(ImmOp), .imem_ack(imem_ack), .imem_req(imem_req),
    .imem_addr(imem_addr), .instr_valid(instr_valid), .PC(PC),
    .redirect_pending(redirect_pending), .trap(trap)
  );

  pc_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .PCsrc(PCsrc),
    .ImmOp(ImmOp), .imem_ack(imem_ack), .imem_req(w_req),
    .imem_addr(w_addr), .instr_valid(w_valid), .PC(w_pc),
    .redirect_pending(w_pend), .trap(w_trap)
  );

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit          upd, busy;
    logic [31:0] npc;
    @(posedge clk);
    if (!rst_n) begin
      m_req = 0; m_hold = 0; m_pend = 0; m_valid = 0; m_trap = 0;
      m_pc = 32'h0; m_tgt = 32'h0;
    end else begin
      busy    = m_req || m_hold;
      upd     = (m_req && imem_ack && !stall) || (m_hold && !stall);
      npc     = PCsrc ? m_pc + ImmOp : (m_pend ? m_tgt : m_pc + 32'd4);
      m_valid = m_req && imem_ack;
      if (m_req) begin
        if (imem_ack) begin
          if (stall) begin m_req = 0; m_hold = 1; end
          else if (!en) m_req = 0;
        end
      end else if (m_hold) begin
        if (!stall) begin m_hold = 0; m_req = en; end
      end else begin
        m_req = en && !m_trap;
      end
      if (upd) begin
        m_pc   = npc;
        m_pend = 0;
`ifdef MISALIGN_TRAP_EN
        if (npc[1:0] != 2'b00) m_trap = 1;
`endif
      end else if (busy && PCsrc) begin
        m_tgt  = m_pc + ImmOp;
        m_pend = 1;
      end
      if (m_trap) begin m_req = 0; m_hold = 0; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 0; stall = 0; PCsrc = 0; ImmOp = '0; imem_ack = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", PC); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", redirect_pending); end
    checks++; if (trap !== 1'b0) begin failures++; $display("FAIL reset_trap got=%b exp=0", trap); end
    checks++; if (w_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_pc_w got=%h exp=fffffffc", w_pc); end
  endtask

  // Plan items 1-4 run back to back from one reset.
  task automatic test_sequential();
    en = 1;
    tick();
    imem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
        failures++; $display("FAIL seq_addr%0d req=%b addr=%h exp_addr=%h", i, imem_req, imem_addr, 32'(i * 4));
      end
      tick();
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", i, instr_valid); end
    end
    imem_ack = 0;
    tick();
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h10) begin
      failures++; $display("FAIL seq_idle valid=%b addr=%h exp valid=0 addr=10", instr_valid, imem_addr);
    end
  endtask

  task automatic test_branch();
    PCsrc = 1; ImmOp = 32'hFFFF_FFF8; imem_ack = 1;
    tick();
    checks++; if (imem_addr !== 32'h08) begin failures++; $display("FAIL branch_back addr=%h exp=08", imem_addr); end
    ImmOp = 32'h20;
    tick();
    checks++; if (imem_addr !== 32'h28) begin failures++; $display("FAIL branch_fwd addr=%h exp=28", imem_addr); end
    ImmOp = 32'h18;
    tick();
    checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL branch_to40 addr=%h exp=40", imem_addr); end
  endtask

  task automatic test_redirect();
    imem_ack = 0; PCsrc = 1; ImmOp = 32'h100;
    tick();
    checks++; if (redirect_pending !== 1'b1 || imem_addr !== 32'h40) begin
      failures++; $display("FAIL redir_capture pend=%b addr=%h exp pend=1 addr=40", redirect_pending, imem_addr);
    end
    PCsrc = 0;
    tick();
    checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL redir_hold pend=%b exp=1", redirect_pending); end
    imem_ack = 1;
    tick();
    checks++; if (imem_addr !== 32'h140 || redirect_pending !== 1'b0) begin
      failures++; $display("FAIL redir_apply addr=%h pend=%b exp addr=140 pend=0", imem_addr, redirect_pending);
    end
  endtask

  task automatic test_stall();
    PCsrc = 1; ImmOp = 32'hFFFF_FEE0; imem_ack = 1;
    tick();
    checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL stall_setup addr=%h exp=20", imem_addr); end
    PCsrc = 0; stall = 1;
    tick();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", instr_valid); end
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0 || PC !== 32'h20) begin
        failures++; $display("FAIL stall_hold%0d req=%b pc=%h exp req=0 pc=20", i, imem_req, PC);
      end
      if (i < 2) tick();
    end
    stall = 0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin
      failures++; $display("FAIL stall_release req=%b addr=%h exp req=1 addr=24", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    en = 1;
    tick();
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_first req=%b addr=%h exp req=1 addr=fffffffc", w_req, w_addr);
    end
    imem_ack = 1;
    tick();
    checks++; if (w_addr !== 32'h0) begin failures++; $display("FAIL wrap_second addr=%h exp=0", w_addr); end
    rst_n = 0;
    #1;
    checks++; if (w_req !== 1'b0 || w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset_w req=%b pc=%h valid=%b exp 0/fffffffc/0", w_req, w_pc, w_valid);
    end
    checks++; if (imem_req !== 1'b0 || PC !== 32'h0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset req=%b pc=%h valid=%b exp 0/0/0", imem_req, PC, instr_valid);
    end
    tick();
    rst_n = 1;
    tick();
    checks++; if (instr_valid !== 1'b0 || w_valid !== 1'b0) begin
      failures++; $display("FAIL ack_after_reset valid=%b/%b exp=0/0", instr_valid, w_valid);
    end
    imem_ack = 0; en = 0;
  endtask

  task automatic test_misalign();
    do_reset();
    en = 1;
    tick();
    PCsrc = 1; ImmOp = 32'h6; imem_ack = 1;
    tick();
    PCsrc = 0; imem_ack = 0;
    checks++; if (PC !== 32'h6) begin failures++; $display("FAIL misalign_pc got=%h exp=6", PC); end
`ifdef MISALIGN_TRAP_EN
    checks++; if (trap !== 1'b1 || imem_req !== 1'b0) begin
      failures++; $display("FAIL misalign_trap trap=%b req=%b exp 1/0", trap, imem_req);
    end
    tick();
    tick();
    checks++; if (imem_req !== 1'b0 || trap !== 1'b1) begin
      failures++; $display("FAIL trap_parked req=%b trap=%b exp 0/1", imem_req, trap);
    end
`else
    checks++; if (trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h6) begin
      failures++; $display("FAIL misalign_fetch trap=%b req=%b addr=%h exp 0/1/6", trap, imem_req, imem_addr);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom % 8) != 0;
      stall    = ($urandom % 4) == 0;
      PCsrc    = ($urandom % 4) == 0;
      ImmOp    = {$urandom_range(0, 2047) - 1024, 2'b00};
      imem_ack = ($urandom % 2) == 1;
      tick();
      checks++; if (imem_req !== m_req || PC !== m_pc || imem_addr !== m_pc) begin
        failures++; $display("FAIL rand_fetch cyc=%0d req=%b pc=%h addr=%h exp req=%b pc=%h", i, imem_req, PC, imem_addr, m_req, m_pc);
      end
      checks++; if (instr_valid !== m_valid || redirect_pending !== m_pend || trap !== m_trap) begin
        failures++; $display("FAIL rand_flags cyc=%0d valid=%b pend=%b trap=%b exp %b/%b/%b", i, instr_valid, redirect_pending, trap, m_valid, m_pend, m_trap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_redirect();
    test_stall();
    test_wrap_reset();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
